mdu_multicycle: RTL and testbench
=================================

Name: mdu_multicycle

Overview:
- Parametrised successor of the pipeline's multiply/divide unit. Sits in EX beside the ALU and owns the HI/LO registers.
- Adds over the current unit: configurable data width and per-class latency; MADD/MADDU/MSUB/MSUBU accumulate ops; a flush input that aborts an in-flight op without touching HI/LO; a decode-stage stall request.
- The pipeline freezes IF/ID and bubbles EX while busy or stall_req is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult-class ops; must be >= 1.
- DIV_CYCLES, 10, busy cycles for div-class ops; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage op valid; sampled on the rising edge.
- op  input  4  EX op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU, 13-15 none.
- id_op  input  4  op of the instruction in ID, same encoding.
- flush  input  1  abort the in-flight op (exception or eret).
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- out  output  WIDTH  combinational: hi when op=MFHI, lo when op=MFLO, else 0.
- busy  output  1  multi-cycle op in flight.
- stall_req  output  1  combinational: id_op in 1..12 and (busy or (start and op in {1,2,3,4,9..12})).

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result cleared.
- States: IDLE and RUN.
- IDLE + start + mult/div-class op + no flush:
  - latch a, b and op at the edge; compute the result into a pending register.
  - load counter with MULT_CYCLES (ops 1,2,9..12) or DIV_CYCLES (ops 3,4); enter RUN.
  - busy goes high the cycle after start.
- RUN: counter decrements each edge. On the edge where the counter goes 1->0: hi/lo take the pending result, busy drops, return to IDLE.
  - With MULT_CYCLES=5 and start sampled at edge k: busy high for cycles k+1..k+5; new hi/lo visible after edge k+5.
- MTHI/MTLO with start in IDLE: write hi or lo at that edge; busy stays low.
- MFHI/MFLO: no state change.
- start while busy: ignored. The pipeline never issues it; the bench checks that it is ignored.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH-bit product.
  - MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- product. Uses the hi/lo values present at the start edge; wraps modulo 2^(2*WIDTH).
  - DIV: quotient truncates toward zero into lo; remainder into hi, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
  - Divide by zero: full latency still runs; hi/lo are left unchanged at completion.
- Flush:
  - in RUN: next edge returns to IDLE, busy=0, hi/lo unchanged, pending result discarded.
  - same edge as start: start ignored, including MTHI/MTLO.
  - flush has priority over completion on the same edge: no commit.
- Reset mid-RUN: immediate return to reset values.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, start one cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; out=0xFFFFFFFA with op=MFLO.
- DIV a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 5, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> busy 0 for the MT ops; after completion hi=6, lo=0. MSUB a=1, b=1 from hi=0, lo=0 -> hi=lo=0xFFFFFFFF.
- DIVU a=9, b=0 with hi=0x11, lo=0x22 -> busy for 10 cycles; hi=0x11, lo=0x22 afterwards.
- MULT started, flush asserted on busy cycle 3 -> busy low the next cycle, hi/lo unchanged; MTLO with flush on the same edge -> lo unchanged.
- busy high with id_op=MFLO -> stall_req=1; start=1, op=DIV, id_op=MULT -> stall_req=1 the same cycle; reset pulled low mid-RUN -> hi=lo=0 and busy=0 immediately.

Source files
------------

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Results are computed at issue and committed after a fixed latency.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [3:0]       id_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             stall_req
);

  localparam int W2   = 2 * WIDTH;
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [W2-1:0]   pend_q, pend_d;
  logic            pv_q, pv_d;

  logic is_mul, is_div, is_acc, is_sub, sgn;
  logic id_md;

  assign is_mul = op inside {OP_MULT, OP_MULTU,
                             OP_MADD, OP_MADDU,
                             OP_MSUB, OP_MSUBU};
  assign is_div = op inside {OP_DIV, OP_DIVU};
  assign is_acc = op inside {OP_MADD, OP_MADDU,
                             OP_MSUB, OP_MSUBU};
  assign is_sub = op inside {OP_MSUB, OP_MSUBU};
  assign sgn    = op inside {OP_MULT, OP_DIV,
                             OP_MADD, OP_MSUB};
  assign id_md  = (id_op >= OP_MULT) &&
                  (id_op <= OP_MSUBU);

  logic [W2-1:0]    a_x, b_x, prod, acc, mres;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag;
  logic [WIDTH-1:0] q, r;
  logic             a_neg, b_neg, b_zero;
  logic [W2-1:0]    res;

  always_comb begin
    a_x  = sgn ? {{WIDTH{a[WIDTH-1]}}, a}
               : {{WIDTH{1'b0}}, a};
    b_x  = sgn ? {{WIDTH{b[WIDTH-1]}}, b}
               : {{WIDTH{1'b0}}, b};
    prod = a_x * b_x;
    acc  = {hi_q, lo_q};
    mres = prod;
    if (is_acc)
      mres = is_sub ? acc - prod : acc + prod;
  end

  // Sign-magnitude divide: MIN / -1 falls out as MIN rem 0.
  always_comb begin
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    b_zero = (b == '0);
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    q_mag  = b_zero ? '0 : a_mag / b_mag;
    r_mag  = b_zero ? '0 : a_mag % b_mag;
    q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r      = a_neg ? -r_mag : r_mag;
    res    = is_div ? {r, q} : mres;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            is_mul: begin
              pend_d  = res;
              pv_d    = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            is_div: begin
              pend_d  = res;
              pv_d    = !b_zero;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            (op == OP_MTHI): hi_d = a;
            (op == OP_MTLO): lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          pv_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            pv_d    = 1'b0;
            if (pv_q)
              {hi_d, lo_d} = pend_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign out  = (op == OP_MFHI) ? hi_q :
                (op == OP_MFLO) ? lo_q : '0;
  assign stall_req = id_md &&
                     (busy || (start && (is_mul || is_div)));

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle.
// Expected HI/LO come from a 64-bit arithmetic model of the op rules.
module tb_mdu_multicycle;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  op = NONE;
  logic [3:0]  id_op = NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo, out;
  logic        busy, stall_req;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sbq[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        prev_busy = 1'b0;
  logic [3:0]  ops [8] = '{MULT, MULTU, DIV, DIVU,
                           MADD, MADDU, MSUB, MSUBU};

  mdu_multicycle dut (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .id_op(id_op), .flush(flush),
    .a(a), .b(b), .hi(hi), .lo(lo), .out(out),
    .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(
      input logic [3:0] o, input logic [31:0] x,
      input logic [31:0] y, input logic [63:0] hl);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      MULT:  return 64'(sx * sy);
      MULTU: return ux * uy;
      MADD:  return hl + 64'(sx * sy);
      MADDU: return hl + ux * uy;
      MSUB:  return hl - 64'(sx * sy);
      MSUBU: return hl - ux * uy;
      DIV: begin
        if (y == 0) return hl;
        if (x == 32'h8000_0000 && y == 32'hffff_ffff)
          return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      DIVU: begin
        if (y == 0) return hl;
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return hl;
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  // Commit monitor: every busy fall pops one expected {hi,lo}.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_done", 64'd1, 64'd0);
        end else begin
          chk("sb_hilo", {hi, lo}, sbq.pop_front());
        end
      end
      prev_busy = busy;
    end
  end

  task automatic mt(input logic [3:0] o,
                    input logic [31:0] x,
                    input bit f);
    @(negedge clk);
    start = 1'b1; op = o; a = x; flush = f;
    id_op = MULT;
    #1 chk("stall_mt", {63'd0, stall_req}, 64'd0);
    id_op = NONE;
    @(negedge clk);
    start = 1'b0; op = NONE; flush = 1'b0;
    if (!f) begin
      if (o == MTHI) m_hi = x;
      else m_lo = x;
    end
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input int fc, input bit poke);
    logic [63:0] e;
    int n, lat;
    lat = (o == DIV || o == DIVU) ? 10 : 5;
    e = (fc > 0) ? {m_hi, m_lo}
                 : model(o, x, y, {m_hi, m_lo});
    sbq.push_back(e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    id_op = MULT;
    #1 chk("stall_issue", {63'd0, stall_req}, 64'd1);
    id_op = NONE;
    @(negedge clk);
    start = 1'b0; op = NONE;
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (n == 1) begin
        id_op = MFLO;
        #1 chk("stall_busy", {63'd0, stall_req}, 64'd1);
        id_op = NONE;
      end
      if (n == fc) flush = 1'b1;
      if (poke && n == 2) begin
        start = 1'b1; op = MTHI; a = ~m_hi;
      end
      @(negedge clk);
      flush = 1'b0; start = 1'b0; op = NONE;
    end
    chk("busy_cycles", 64'(n), 64'((fc > 0) ? fc : lat));
  endtask

  task automatic chk_out();
    @(negedge clk);
    op = MFLO;
    #1 chk("out_mflo", {32'd0, out}, {32'd0, m_lo});
    op = MFHI;
    #1 chk("out_mfhi", {32'd0, out}, {32'd0, m_hi});
    op = NONE;
    #1 chk("out_none", {32'd0, out}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] o;
    logic [31:0] x, y;
    int fc, lat;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;

    issue(MULT, 32'hffff_fffe, 32'd3, 0, 0);
    chk("mult_hi", {32'd0, hi}, 64'hffff_ffff);
    chk("mult_lo", {32'd0, lo}, 64'hffff_fffa);
    chk_out();

    issue(DIV, 32'hffff_fff9, 32'd2, 0, 0);
    chk("div_lo", {32'd0, lo}, 64'hffff_fffd);
    chk("div_hi", {32'd0, hi}, 64'hffff_ffff);
    issue(DIVU, 32'd7, 32'd2, 0, 0);
    chk("divu_lo", {32'd0, lo}, 64'd3);
    chk("divu_hi", {32'd0, hi}, 64'd1);
    issue(DIV, 32'h8000_0000, 32'hffff_ffff, 0, 0);
    chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);
    chk("ovf_hi", {32'd0, hi}, 64'd0);

    mt(MTHI, 32'd5, 0);
    mt(MTLO, 32'hffff_ffff, 0);
    issue(MADDU, 32'd1, 32'd1, 0, 0);
    chk("maddu_hi", {32'd0, hi}, 64'd6);
    chk("maddu_lo", {32'd0, lo}, 64'd0);
    mt(MTHI, 32'd0, 0);
    mt(MTLO, 32'd0, 0);
    issue(MSUB, 32'd1, 32'd1, 0, 0);
    chk("msub_hilo", {hi, lo}, 64'hffff_ffff_ffff_ffff);

    mt(MTHI, 32'h11, 0);
    mt(MTLO, 32'h22, 0);
    issue(DIVU, 32'd9, 32'd0, 0, 1);
    chk("dz_hi", {32'd0, hi}, 64'h11);
    chk("dz_lo", {32'd0, lo}, 64'h22);

    issue(MULT, 32'h1234, 32'h5678, 3, 0);
    chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});
    mt(MTLO, 32'h99, 1);

    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = NONE;
    @(negedge clk);
    sbq.push_back(64'd0);
    #2 reset = 1'b0;
    #1 chk("rstrun_busy", {63'd0, busy}, 64'd0);
    chk("rstrun_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt(($urandom_range(0, 1) != 0) ? MTLO : MTHI,
           rnd(), $urandom_range(0, 5) == 0);
      end else begin
        o = ops[$urandom_range(0, 7)];
        x = rnd();
        y = rnd();
        lat = (o == DIV || o == DIVU) ? 10 : 5;
        fc = ($urandom_range(0, 7) == 0) ?
             $urandom_range(1, lat) : 0;
        issue(o, x, y, fc, 0);
      end
    end
    chk_out();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
